alu_exec_unit: RTL

//  Sequential responder for 64-bit ALU requests; same op encoding/semantics as the combinational ALU wrapper.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_exec_unit_if.sv | 38 +++
 rtl/alu_shift_step.sv | 25 ++
 rtl/alu_exec_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, FSM state encodings and an op-class helper.
// Used by alu_exec_unit, the combinational ALU wrapper and the testbenches.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response channel bundle for alu_exec_unit.
// resp_flags exists only when ALU_FLAGS_EN is defined.
interface alu_exec_unit_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [XLEN-1:0]  req_a;
    logic [XLEN-1:0]  req_b;
    logic [3:0]       req_op;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_result;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err;
`ifdef ALU_FLAGS_EN
    logic [3:0]       resp_flags;
`endif

    modport master (
`ifdef ALU_FLAGS_EN
        input  resp_flags,
`endif
        output req_valid, req_a, req_b, req_op, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_tag, resp_err
    );

    modport slave (
`ifdef ALU_FLAGS_EN
        output resp_flags,
`endif
        input  req_valid, req_a, req_b, req_op, req_tag, resp_ready,
        output req_ready, resp_valid, resp_result, resp_tag, resp_err
    );

endinterface

// File: rtl/alu_shift_step.sv
// One bounded shift step: shifts value_i by amt_i (<= SHIFT_STEP) as SRL, SLL or SRA.
// Kept narrow so the iterative shifter never needs a full-width barrel.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned SHIFT_STEP = 8,
    localparam int unsigned SW        = $clog2(SHIFT_STEP) + 1
) (
    input  logic [XLEN-1:0] value_i,
    input  logic [SW-1:0]   amt_i,
    input  logic [3:0]      kind_i,
    output logic [XLEN-1:0] shifted_o
);

    // Select shift flavour; anything not SLL/SRA is treated as SRL.
    always_comb begin
        case (kind_i)
            OP_SLL:  shifted_o = value_i << amt_i;
            OP_SRA:  shifted_o = $unsigned($signed(value_i) >>> amt_i);
            default: shifted_o = value_i >> amt_i;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Sequential 64-bit ALU responder with valid/ready request and response channels.
// Shifts iterate SHIFT_STEP bits per cycle; all other ops answer one cycle after acceptance.
// Optional feature macro: ALU_FLAGS_EN adds registered {N,Z,C,V} on resp_flags.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned TAG_W      = 4,
    parameter int unsigned SHIFT_STEP = 8
) (
    input logic             clk,
    input logic             rst_n,
    alu_exec_unit_if.slave  bus
);

    localparam int unsigned LW = $clog2(XLEN);
    localparam int unsigned SW = $clog2(SHIFT_STEP) + 1;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  work_q, work_d;
    logic [LW-1:0]    rem_q, rem_d;
    logic [3:0]       kind_q, kind_d;
    logic             resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             err_q, err_d;
`ifdef ALU_FLAGS_EN
    logic [3:0]       flags_q, flags_d;
    logic             alu_c, alu_v;
`endif

    logic             accept;
    logic [LW-1:0]    req_amt;
    logic [XLEN-1:0]  alu_res;
    logic             alu_err;
    logic             take_full;
    logic [SW-1:0]    step_amt;
    logic [LW-1:0]    rem_next;
    logic [XLEN-1:0]  shifted;

    assign bus.req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.resp_ready);
    assign accept        = bus.req_valid && bus.req_ready;
    assign req_amt       = bus.req_b[LW-1:0];

    // Combinational ALU on the live request; only sampled at acceptance.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (bus.req_op)
            OP_ADD:  alu_res = bus.req_a + bus.req_b;
            OP_SUB:  alu_res = bus.req_a - bus.req_b;
            OP_AND:  alu_res = bus.req_a & bus.req_b;
            OP_OR:   alu_res = bus.req_a | bus.req_b;
            OP_XOR:  alu_res = bus.req_a ^ bus.req_b;
            // Only reached with a zero shift amount; nonzero amounts go through ST_SHIFT.
            OP_SRL, OP_SLL, OP_SRA: alu_res = bus.req_a;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(bus.req_a) < $signed(bus.req_b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, bus.req_a < bus.req_b};
            default: alu_err = 1'b1;
        endcase
    end

`ifdef ALU_FLAGS_EN
    // Carry and signed overflow for ADD/SUB; zero for every other op.
    always_comb begin
        logic [XLEN:0] add_ext;
        add_ext = {1'b0, bus.req_a} + {1'b0, bus.req_b};
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        if (bus.req_op == OP_ADD) begin
            alu_c = add_ext[XLEN];
            alu_v = (bus.req_a[XLEN-1] == bus.req_b[XLEN-1]) &&
                    (alu_res[XLEN-1] != bus.req_a[XLEN-1]);
        end else if (bus.req_op == OP_SUB) begin
            alu_c = (bus.req_a >= bus.req_b);
            alu_v = (bus.req_a[XLEN-1] != bus.req_b[XLEN-1]) &&
                    (alu_res[XLEN-1] != bus.req_a[XLEN-1]);
        end
    end
`endif

    // With SHIFT_STEP == XLEN every remaining amount fits in a single step.
    if (SHIFT_STEP >= XLEN) begin : g_step_full
        assign take_full = 1'b0;
    end else begin : g_step_part
        assign take_full = (rem_q >= LW'(SHIFT_STEP));
    end

    assign step_amt = take_full ? SW'(SHIFT_STEP) : SW'(rem_q);
    assign rem_next = take_full ? rem_q - LW'(SHIFT_STEP) : '0;

    alu_shift_step #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift_step (
        .value_i   (work_q),
        .amt_i     (step_amt),
        .kind_i    (kind_q),
        .shifted_o (shifted)
    );

    // Next-state: FSM transitions, shift iteration and response register loads.
    always_comb begin
        state_d      = state_q;
        work_d       = work_q;
        rem_d        = rem_q;
        kind_d       = kind_q;
        resp_valid_d = resp_valid_q;
        result_d     = result_q;
        tag_d        = tag_q;
        err_d        = err_q;
`ifdef ALU_FLAGS_EN
        flags_d      = flags_q;
`endif
        case (state_q)
            ST_SHIFT: begin
                work_d = shifted;
                rem_d  = rem_next;
                if (rem_next == '0) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    result_d     = shifted;
                    err_d        = 1'b0;
`ifdef ALU_FLAGS_EN
                    flags_d      = {shifted[XLEN-1], shifted == '0, 2'b00};
`endif
                end
            end
            default: begin
                if ((state_q == ST_RESP) && bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
                if (accept) begin
                    tag_d = bus.req_tag;
                    if (is_shift_op(bus.req_op) && (req_amt != '0)) begin
                        state_d      = ST_SHIFT;
                        work_d       = bus.req_a;
                        rem_d        = req_amt;
                        kind_d       = bus.req_op;
                        resp_valid_d = 1'b0;
                        err_d        = 1'b0;
                    end else begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        result_d     = alu_res;
                        err_d        = alu_err;
`ifdef ALU_FLAGS_EN
                        flags_d      = {alu_res[XLEN-1], alu_res == '0, alu_c, alu_v};
`endif
                    end
                end
            end
        endcase
    end

    // State and response registers; reset drops any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            work_q       <= '0;
            rem_q        <= '0;
            kind_q       <= '0;
            resp_valid_q <= 1'b0;
            result_q     <= '0;
            tag_q        <= '0;
            err_q        <= 1'b0;
`ifdef ALU_FLAGS_EN
            flags_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            work_q       <= work_d;
            rem_q        <= rem_d;
            kind_q       <= kind_d;
            resp_valid_q <= resp_valid_d;
            result_q     <= result_d;
            tag_q        <= tag_d;
            err_q        <= err_d;
`ifdef ALU_FLAGS_EN
            flags_q      <= flags_d;
`endif
        end
    end

    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = result_q;
    assign bus.resp_tag    = tag_q;
    assign bus.resp_err    = err_q;
`ifdef ALU_FLAGS_EN
    assign bus.resp_flags  = flags_q;
`endif

endmodule
